// File: rtl/nn_out_wb.sv
// Output write-back stage: shift / ReLU / saturate / optional pair max-pool,
// then packs byte pairs into 16-bit DMA writes, one tile per start pulse.
module nn_out_wb #(
    parameter int DATA_WIDTH     = 8,
    parameter int OUT_WIDTH      = 16,
    parameter int DMA_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic                      i_relu,
    input  logic                      i_pool,
    input  logic [3:0]                i_psum_shift,
    input  logic [DMA_ADDR_WIDTH-1:0] i_base_addr,
    input  logic [CNT_WIDTH-1:0]      i_out_count,
    input  logic                      i_valid,
    input  logic [OUT_WIDTH-1:0]      i_result,
    output logic                      o_ready,
    output logic                      o_dma_wr_en,
    output logic [DMA_ADDR_WIDTH-1:0] o_dma_wr_addr,
    output logic [2*DATA_WIDTH-1:0]   o_dma_wr_data,
    output logic                      o_busy,
    output logic                      o_done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic signed [OUT_WIDTH-1:0] QMAX = OUT_WIDTH'(2**(DATA_WIDTH-1) - 1);
    localparam logic signed [OUT_WIDTH-1:0] QMIN = OUT_WIDTH'(-(2**(DATA_WIDTH-1)));
    localparam logic [CNT_WIDTH:0]          ONE  = {{CNT_WIDTH{1'b0}}, 1'b1};

    state_t state_reg, state_next;

    // Latched tile configuration
    logic                      relu_reg;
    logic                      pool_reg;
    logic [3:0]                shift_reg;
    logic [DMA_ADDR_WIDTH-1:0] addr_reg;
    logic [CNT_WIDTH:0]        remain_reg;

    // Input capture, quantize, pool, pack stages
    logic                      in_v_reg;
    logic [OUT_WIDTH-1:0]      in_data_reg;
    logic                      s1_v_reg;
    logic [DATA_WIDTH-1:0]     s1_q_reg;
    logic                      pair_reg;
    logic [DATA_WIDTH-1:0]     held_reg;
    logic                      s2_v_reg;
    logic [DATA_WIDTH-1:0]     s2_b_reg;
    logic                      hi_reg;
    logic [DATA_WIDTH-1:0]     low_reg;

    logic                      wr_en_reg;
    logic [DMA_ADDR_WIDTH-1:0] wr_addr_reg;
    logic [2*DATA_WIDTH-1:0]   wr_data_reg;

    logic                        accept;
    logic                        pipe_empty;
    logic                        pad;
    logic signed [OUT_WIDTH-1:0] shifted;
    logic signed [OUT_WIDTH-1:0] clipped;
    logic [DATA_WIDTH-1:0]       sat_q;
    logic [DATA_WIDTH-1:0]       pool_max;

    assign o_ready    = (state_reg == RUN) && (remain_reg != '0);
    assign accept     = i_valid && o_ready;
    assign pipe_empty = !in_v_reg && !s1_v_reg && !s2_v_reg;
    // A lone low byte left after the pipeline drains is flushed with a zero high byte
    assign pad        = (state_reg == DRAIN) && pipe_empty && hi_reg;

    assign o_busy        = (state_reg != IDLE);
    assign o_done        = (state_reg == DONE);
    assign o_dma_wr_en   = wr_en_reg;
    assign o_dma_wr_addr = wr_addr_reg;
    assign o_dma_wr_data = wr_data_reg;

    always_comb begin
        shifted = $signed(in_data_reg) >>> shift_reg;
        clipped = shifted;
        if (relu_reg && shifted < 0) begin
            clipped = '0;
        end
        if (clipped > QMAX) begin
            sat_q = QMAX[DATA_WIDTH-1:0];
        end else if (clipped < QMIN) begin
            sat_q = QMIN[DATA_WIDTH-1:0];
        end else begin
            sat_q = clipped[DATA_WIDTH-1:0];
        end
    end

    assign pool_max = ($signed(held_reg) > $signed(s1_q_reg)) ? held_reg : s1_q_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    state_next = (i_out_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept && remain_reg == ONE) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pipe_empty && !hi_reg) begin
                    state_next = DONE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg   <= IDLE;
            relu_reg    <= 1'b0;
            pool_reg    <= 1'b0;
            shift_reg   <= '0;
            addr_reg    <= '0;
            remain_reg  <= '0;
            in_v_reg    <= 1'b0;
            in_data_reg <= '0;
            s1_v_reg    <= 1'b0;
            s1_q_reg    <= '0;
            pair_reg    <= 1'b0;
            held_reg    <= '0;
            s2_v_reg    <= 1'b0;
            s2_b_reg    <= '0;
            hi_reg      <= 1'b0;
            low_reg     <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            state_reg <= state_next;

            if (state_reg == IDLE && i_start) begin
                relu_reg   <= i_relu;
                pool_reg   <= i_pool;
                shift_reg  <= i_psum_shift;
                addr_reg   <= i_base_addr;
                remain_reg <= i_pool ? {i_out_count, 1'b0} : {1'b0, i_out_count};
                pair_reg   <= 1'b0;
                hi_reg     <= 1'b0;
            end

            if (accept) begin
                remain_reg  <= remain_reg - ONE;
                in_data_reg <= i_result;
            end
            in_v_reg <= accept;

            s1_v_reg <= in_v_reg;
            if (in_v_reg) begin
                s1_q_reg <= sat_q;
            end

            s2_v_reg <= 1'b0;
            if (s1_v_reg) begin
                if (!pool_reg) begin
                    s2_b_reg <= s1_q_reg;
                    s2_v_reg <= 1'b1;
                end else if (!pair_reg) begin
                    held_reg <= s1_q_reg;
                    pair_reg <= 1'b1;
                end else begin
                    s2_b_reg <= pool_max;
                    s2_v_reg <= 1'b1;
                    pair_reg <= 1'b0;
                end
            end

            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
            if (s2_v_reg) begin
                if (!hi_reg) begin
                    low_reg <= s2_b_reg;
                    hi_reg  <= 1'b1;
                end else begin
                    wr_en_reg   <= 1'b1;
                    wr_addr_reg <= addr_reg;
                    wr_data_reg <= {s2_b_reg, low_reg};
                    addr_reg    <= addr_reg + 1'b1;
                    hi_reg      <= 1'b0;
                end
            end else if (pad) begin
                wr_en_reg   <= 1'b1;
                wr_addr_reg <= addr_reg;
                wr_data_reg <= {{DATA_WIDTH{1'b0}}, low_reg};
                addr_reg    <= addr_reg + 1'b1;
                hi_reg      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nn_out_wb.sv
// Directed bench for nn_out_wb: a model pushes expected DMA writes (address,
// data, cycle) to a scoreboard; a negedge monitor pops and checks them.
module tb_nn_out_wb;

    localparam int AW = 5;
    localparam int CW = 16;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          i_start = 1'b0;
    logic          i_relu = 1'b0;
    logic          i_pool = 1'b0;
    logic [3:0]    i_psum_shift = '0;
    logic [AW-1:0] i_base_addr = '0;
    logic [CW-1:0] i_out_count = '0;
    logic          i_valid = 1'b0;
    logic [15:0]   i_result = '0;
    logic          o_ready;
    logic          o_dma_wr_en;
    logic [AW-1:0] o_dma_wr_addr;
    logic [15:0]   o_dma_wr_data;
    logic          o_busy;
    logic          o_done;

    nn_out_wb dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_relu        (i_relu),
        .i_pool        (i_pool),
        .i_psum_shift  (i_psum_shift),
        .i_base_addr   (i_base_addr),
        .i_out_count   (i_out_count),
        .i_valid       (i_valid),
        .i_result      (i_result),
        .o_ready       (o_ready),
        .o_dma_wr_en   (o_dma_wr_en),
        .o_dma_wr_addr (o_dma_wr_addr),
        .o_dma_wr_data (o_dma_wr_data),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   data;
        int            cyc;
    } wr_t;

    wr_t         sb[$];
    wr_t         mon_e;
    bit          mon_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] smp [0:7];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (mon_en) begin
            if (o_dma_wr_en) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", 32'(o_dma_wr_en), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("wr_addr", 32'(o_dma_wr_addr), 32'(mon_e.addr));
                    chk("wr_data", 32'(o_dma_wr_data), 32'(mon_e.data));
                    chk("wr_cycle", cyc, mon_e.cyc);
                end
            end else begin
                chk("idle_wr_addr", 32'(o_dma_wr_addr), 32'd0);
                chk("idle_wr_data", 32'(o_dma_wr_data), 32'd0);
            end
        end
    end

    function automatic logic [7:0] quant(input logic [15:0] v, input int sh, input bit relu);
        int s;
        s = int'($signed(v));
        s = s >>> sh;
        if (relu && s < 0) s = 0;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s[7:0];
    endfunction

    task automatic do_start(input logic [AW-1:0] base, input int count, input int sh,
                            input bit relu, input bit pool);
        @(negedge i_clk);
        i_base_addr  = base;
        i_out_count  = CW'(count);
        i_psum_shift = 4'(sh);
        i_relu       = relu;
        i_pool       = pool;
        i_start      = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic send(input logic [15:0] v, output int k);
        @(negedge i_clk);
        chk("ready_before_accept", 32'(o_ready), 32'd1);
        i_valid  = 1'b1;
        i_result = v;
        @(posedge i_clk);
        #1;
        k = cyc;
        i_valid = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ready"}, 32'(o_ready), 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_done"}, 32'(o_done), 32'd0);
        chk({tag, "_wr_en"}, 32'(o_dma_wr_en), 32'd0);
        chk({tag, "_wr_addr"}, 32'(o_dma_wr_addr), 32'd0);
        chk({tag, "_wr_data"}, 32'(o_dma_wr_data), 32'd0);
    endtask

    task automatic run_tile(input logic [AW-1:0] base, input int count, input int sh,
                            input bit relu, input bit pool, input int gap,
                            input bit inject, input bit extra);
        logic [AW-1:0] addr;
        logic [7:0]    q, b, low, held;
        int            k, bi, n, last_wr, dcyc;
        bit            emit, got;
        wr_t           e;
        addr = base; bi = 0; k = 0; last_wr = 0; dcyc = 0; low = '0; held = '0; b = '0;
        n = count << pool;
        do_start(base, count, sh, relu, pool);
        chk("busy_after_start", 32'(o_busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            send(smp[i], k);
            q = quant(smp[i], sh, relu);
            emit = 1'b1;
            if (pool) begin
                if (i % 2 == 0) begin
                    held = q;
                    emit = 1'b0;
                end else begin
                    b = ($signed(held) > $signed(q)) ? held : q;
                end
            end else begin
                b = q;
            end
            if (emit) begin
                if (bi % 2 == 0) begin
                    low = b;
                end else begin
                    e.addr = addr; e.data = {b, low}; e.cyc = k + 3;
                    sb.push_back(e);
                    addr++;
                    last_wr = k + 3;
                end
                bi++;
            end
            if (inject && i == 0) begin
                // start pulse with a different configuration mid-tile must be ignored
                @(negedge i_clk);
                i_start = 1'b1; i_psum_shift = 4'd9; i_relu = ~relu; i_pool = ~pool;
                i_base_addr = '0; i_out_count = '0;
                @(posedge i_clk);
                #1;
                i_start = 1'b0;
            end
            if (i < n - 1) repeat (gap) @(negedge i_clk);
        end
        if (bi % 2 == 1) begin
            e.addr = addr; e.data = {8'h00, low}; e.cyc = k + 4;
            sb.push_back(e);
            last_wr = k + 4;
        end
        chk("ready_low_after_last", 32'(o_ready), 32'd0);
        chk("busy_in_drain", 32'(o_busy), 32'd1);
        if (extra) begin
            @(negedge i_clk);
            chk("ready_low_extra_valid", 32'(o_ready), 32'd0);
            i_valid = 1'b1; i_result = 16'h007F;
            @(posedge i_clk);
            #1;
            i_valid = 1'b0;
        end
        got = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge i_clk);
            if (o_done) begin
                got = 1'b1;
                dcyc = cyc;
                break;
            end
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("done_cycle", dcyc, last_wr + 1);
        chk("sb_drained", sb.size(), 32'd0);
        @(negedge i_clk);
        chk("done_one_cycle", 32'(o_done), 32'd0);
        chk("idle_after_done", 32'(o_busy), 32'd0);
    endtask

    initial begin
        int k;
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        check_outputs_zero("reset");
        i_rst = 1'b1;
        mon_en = 1'b1;

        // shift by 4 with negative saturation
        smp[0] = 16'h0100; smp[1] = 16'hF000;
        run_tile(5'd3, 2, 4, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        // ReLU plus positive clamp
        smp[0] = 16'hFFFB; smp[1] = 16'h012C; smp[2] = 16'h0007; smp[3] = 16'h8000;
        run_tile(5'd8, 4, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0);

        // pairwise max-pool, extra valid after the last accept is dropped
        smp[0] = 16'h0003; smp[1] = 16'hFFF7; smp[2] = 16'hFFFE; smp[3] = 16'hFFFF;
        run_tile(5'd12, 2, 0, 1'b0, 1'b1, 0, 1'b0, 1'b1);

        // odd count, address wraps from 31 to 0
        smp[0] = 16'h0001; smp[1] = 16'h0002; smp[2] = 16'h0003;
        run_tile(5'd31, 3, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        // zero-count tile: one busy cycle with done, no write
        do_start(5'd2, 0, 0, 1'b0, 1'b0);
        chk("zero_busy", 32'(o_busy), 32'd1);
        chk("zero_done", 32'(o_done), 32'd1);
        chk("zero_ready", 32'(o_ready), 32'd0);
        @(posedge i_clk);
        #1;
        chk("zero_idle_busy", 32'(o_busy), 32'd0);
        chk("zero_idle_done", 32'(o_done), 32'd0);

        // back-to-back start, valid gaps, ignored mid-tile start
        smp[0] = 16'h000A; smp[1] = 16'h0014; smp[2] = 16'h001E; smp[3] = 16'h0028;
        run_tile(5'd17, 4, 1, 1'b0, 1'b0, 2, 1'b1, 1'b0);

        // reset mid-tile aborts, next tile writes from its own base
        do_start(5'd10, 4, 0, 1'b0, 1'b0);
        send(16'h0055, k);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check_outputs_zero("midreset");
        repeat (3) @(negedge i_clk);
        i_rst = 1'b1;
        chk("after_reset_busy", 32'(o_busy), 32'd0);
        smp[0] = 16'h0021; smp[1] = 16'h0043;
        run_tile(5'd20, 2, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        repeat (3) @(negedge i_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
